// File: rtl/uart_pkg.sv
// Shared UART defaults: FIFO geometry and the bit positions of the per-word
// receive error flags.
package uart_pkg;
   localparam int DATA_WIDTH_DEF = 8;
   localparam int DEPTH_DEF      = 16;
   localparam int ERR_PAR        = 1;
   localparam int ERR_FRM        = 0;
endpackage

// File: rtl/uart_rx_fifo_v2_strobe_cond.sv
// Strobe conditioning: passes a strobe straight through, or reduces it to a
// one-cycle pulse on its rising edge when EDGE_MODE is 1.
module strobe_cond #(
   parameter int EDGE_MODE = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic strobe,
   output logic pulse
);
   logic strobe_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) strobe_d <= 1'b0;
      else     strobe_d <= strobe;
   end

   generate
      if (EDGE_MODE != 0) begin : g_edge
         assign pulse = strobe & ~strobe_d;
      end else begin : g_level
         assign pulse = strobe;
      end
   endgenerate
endmodule

// File: rtl/uart_rx_fifo_v2.sv
// UART receive FIFO with registered read data, threshold and sticky overrun.
// Define UART_RX_FIFO_ERR_EN to store {parity_err, frame_err} with each word.
module uart_rx_fifo_v2
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int DEPTH      = DEPTH_DEF,
   parameter int EDGE_MODE  = 1,
   localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [1:0]            err_in,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH:0]   thresh,
   input  logic                  clr_ovr,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [1:0]            err_out,
   output logic                  empty,
   output logic                  full,
   output logic [ADDR_WIDTH:0]   level,
   output logic                  thresh_hit,
   output logic                  overrun
);
   localparam logic [ADDR_WIDTH:0] FULL_LVL = (ADDR_WIDTH+1)'(DEPTH);

`ifdef UART_RX_FIFO_ERR_EN
   localparam int EW = DATA_WIDTH + 2;
`else
   localparam int EW = DATA_WIDTH;
`endif

   logic                  we, re, wr_acc, rd_acc;
   logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
   logic [ADDR_WIDTH:0]   lvl_q;
   logic [EW-1:0]         mem [DEPTH];
   logic [EW-1:0]         wdata, rdata_q;

   strobe_cond #(.EDGE_MODE(EDGE_MODE)) u_wr_cond (
      .clk(clk), .rst(rst), .strobe(wr_en), .pulse(we));
   strobe_cond #(.EDGE_MODE(EDGE_MODE)) u_rd_cond (
      .clk(clk), .rst(rst), .strobe(rd_en), .pulse(re));

   // Full blocks the write and empty blocks the read, which yields the
   // read-wins-when-full and write-wins-when-empty behaviour directly.
   assign wr_acc = we & ~full;
   assign rd_acc = re & ~empty;

`ifdef UART_RX_FIFO_ERR_EN
   assign wdata   = {err_in[ERR_PAR], err_in[ERR_FRM], data_in};
   assign err_out = {rdata_q[DATA_WIDTH+1], rdata_q[DATA_WIDTH]};
`else
   logic unused_err;
   assign unused_err = ^err_in;
   assign wdata      = data_in;
   assign err_out    = 2'b00;
`endif
   assign data_out = rdata_q[DATA_WIDTH-1:0];

   // Storage has no reset; contents are meaningless once the pointers clear.
   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         lvl_q   <= '0;
         rdata_q <= '0;
         overrun <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
         if (rd_acc) begin
            rd_ptr  <= rd_ptr + 1'b1;
            rdata_q <= mem[rd_ptr];
         end
         if (wr_acc && !rd_acc)      lvl_q <= lvl_q + 1'b1;
         else if (rd_acc && !wr_acc) lvl_q <= lvl_q - 1'b1;
         if (we && full)   overrun <= 1'b1;
         else if (clr_ovr) overrun <= 1'b0;
      end
   end

   assign level      = lvl_q;
   assign empty      = (lvl_q == '0);
   assign full       = (lvl_q == FULL_LVL);
   assign thresh_hit = (thresh != '0) && (lvl_q >= thresh);
endmodule
